// File: rtl/rs_omega_shift_ctrl.sv
// ----------------------------------------------------------------------------
// rs_omega_shift_ctrl
//
// Omega-shift sequencer between the key-equation (Euclide) engine and the
// Forney error-value stage of the RS decoder.
//
// A start pulse latches omega_8..omega_15 and a shift amount s. The block
// then builds the shifted coefficients
//   omegaShifted_i = omega_(i+s) when i+s <= 15, otherwise 0
// and streams them out one symbol per cycle over a valid/ready handshake.
//
// Optional build macro: RS_OMEGA_AUTO_SHIFT_EN
//   When defined, numShiftedIn is ignored. The shift is found by scanning
//   omega_8, omega_9, ... (one per cycle, in a SCAN state) for the first
//   nonzero coefficient. If all eight are zero, s = 16 is used.
//
// Ports
//   CLK           in   clock, rising edge
//   RESET         in   asynchronous reset, active high
//   enable        in   clock enable; low freezes every register
//   startPls      in   one-cycle start request
//   numShiftedIn  in   shift amount; the legal range is 8..15
//   omegaIn       in   omega_8..omega_15 packed; omega_8 is in [7:0]
//   outReady      in   downstream ready
//   outValid      out  outData is valid
//   outData       out  shifted coefficient omegaShifted_outIndex
//   outIndex      out  coefficient index 0..NCOEF-1
//   outLast       out  high together with the final index
//   busy          out  block is not idle
//   shiftUsed     out  shift applied to the current or most recent block
//   errShift      out  current or most recent block had an illegal shift
//   errOverrun    out  a start arrived while busy (sticky until RESET)
// ----------------------------------------------------------------------------
module rs_omega_shift_ctrl #(
  parameter int SYM_W     = 8,
  parameter int NCOEF     = 8,
  parameter int SHIFT_MIN = 8
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       enable,
  input  logic                       startPls,
  input  logic [4:0]                 numShiftedIn,
  input  logic [SYM_W*NCOEF-1:0]     omegaIn,
  input  logic                       outReady,
  output logic                       outValid,
  output logic [SYM_W-1:0]           outData,
  output logic [$clog2(NCOEF)-1:0]   outIndex,
  output logic                       outLast,
  output logic                       busy,
  output logic [4:0]                 shiftUsed,
  output logic                       errShift,
  output logic                       errOverrun
);

  localparam int IDX_W     = $clog2(NCOEF);
  localparam int SHIFT_MAX = SHIFT_MIN + NCOEF - 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCOEF - 1);

`ifdef RS_OMEGA_AUTO_SHIFT_EN
  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_STREAM} state_t;
`else
  typedef enum logic [0:0] {ST_IDLE, ST_STREAM} state_t;
`endif

  state_t r_state;
  state_t w_state_next;

  logic [SYM_W-1:0] r_coef [NCOEF];
  logic [IDX_W-1:0] r_idx;
  logic [4:0]       r_shift_used;
  logic             r_err_shift;
  logic             r_err_overrun;

  logic             w_accept_start;
  logic             w_overrun;
  logic             w_xfer;
  logic             w_xfer_last;
  logic             w_load;
  logic [4:0]       w_load_shift;
  logic             w_load_err;
  logic [SYM_W*NCOEF-1:0] w_omega_raw;
  logic [SYM_W-1:0] w_omega_src  [NCOEF];
  logic [SYM_W-1:0] w_coef_load  [NCOEF];

  // Handshake qualifiers; every state change is gated by enable.
  assign w_accept_start = enable && startPls && (r_state == ST_IDLE);
  assign w_overrun      = enable && startPls && (r_state != ST_IDLE);
  assign w_xfer         = enable && outReady && (r_state == ST_STREAM);
  assign w_xfer_last    = w_xfer && (r_idx == LAST_IDX);

`ifdef RS_OMEGA_AUTO_SHIFT_EN
  logic [SYM_W*NCOEF-1:0] r_hold;
  logic [IDX_W-1:0]       r_scan_cnt;
  logic                   w_scan_hit;
  logic [4:0]             w_unused_shift_in;

  // The shift comes from the scan, so the shift input is intentionally unused.
  assign w_unused_shift_in = numShiftedIn;

  assign w_omega_raw = r_hold;
  assign w_scan_hit  = (w_omega_src[r_scan_cnt] != '0);
  // Load on the first nonzero coefficient, or after the last one is tested.
  assign w_load       = enable && (r_state == ST_SCAN) &&
                        (w_scan_hit || (r_scan_cnt == LAST_IDX));
  assign w_load_shift = w_scan_hit ? (5'(SHIFT_MIN) + 5'(r_scan_cnt))
                                   : 5'(SHIFT_MAX + 1);
  // The scanned shift is legal by construction; s = 16 just yields all-zero data.
  assign w_load_err   = 1'b0;
`else
  assign w_omega_raw  = omegaIn;
  assign w_load       = w_accept_start;
  assign w_load_shift = numShiftedIn;
  assign w_load_err   = (numShiftedIn < 5'(SHIFT_MIN)) ||
                        (numShiftedIn > 5'(SHIFT_MAX));
`endif

  // Unpack the omega bus and build the shifted coefficient set to be loaded.
  for (genvar gi = 0; gi < NCOEF; gi++) begin : g_coef
    logic [5:0]       w_pos;
    logic [IDX_W-1:0] w_rel;

    assign w_omega_src[gi] = w_omega_raw[gi*SYM_W +: SYM_W];
    // w_pos is the omega index feeding slot gi. Any legal shift keeps
    // w_pos >= SHIFT_MIN, so only the upper bound needs a test.
    assign w_pos = 6'(gi) + {1'b0, w_load_shift};
    assign w_rel = IDX_W'(w_pos - 6'(SHIFT_MIN));
    assign w_coef_load[gi] = (!w_load_err && (w_pos <= 6'(SHIFT_MAX)))
                             ? w_omega_src[w_rel] : '0;
  end

  // State register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= ST_IDLE;
    end else if (enable) begin
      r_state <= w_state_next;
    end
  end

  // Next-state and output decode.
  always_comb begin
    w_state_next = r_state;
    outValid     = 1'b0;
    outData      = '0;
    outIndex     = r_idx;
    outLast      = 1'b0;
    busy         = (r_state != ST_IDLE);

    case (r_state)
      ST_IDLE: begin
        if (w_accept_start) begin
`ifdef RS_OMEGA_AUTO_SHIFT_EN
          w_state_next = ST_SCAN;
`else
          w_state_next = ST_STREAM;
`endif
        end
      end
`ifdef RS_OMEGA_AUTO_SHIFT_EN
      ST_SCAN: begin
        if (w_load) begin
          w_state_next = ST_STREAM;
        end
      end
`endif
      ST_STREAM: begin
        outValid = 1'b1;
        outData  = r_coef[r_idx];
        outLast  = (r_idx == LAST_IDX);
        if (w_xfer_last) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Datapath and status registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NCOEF; i++) begin
        r_coef[i] <= '0;
      end
      r_idx         <= '0;
      r_shift_used  <= '0;
      r_err_shift   <= 1'b0;
      r_err_overrun <= 1'b0;
`ifdef RS_OMEGA_AUTO_SHIFT_EN
      r_hold        <= '0;
      r_scan_cnt    <= '0;
`endif
    end else if (enable) begin
`ifdef RS_OMEGA_AUTO_SHIFT_EN
      if (w_accept_start) begin
        r_hold      <= omegaIn;
        r_scan_cnt  <= '0;
        r_err_shift <= 1'b0;
      end else if ((r_state == ST_SCAN) && !w_load) begin
        r_scan_cnt  <= r_scan_cnt + 1'b1;
      end
`endif
      if (w_load) begin
        for (int i = 0; i < NCOEF; i++) begin
          r_coef[i] <= w_coef_load[i];
        end
        r_shift_used <= w_load_shift;
        r_err_shift  <= w_load_err;
      end
      if (w_xfer) begin
        r_idx <= w_xfer_last ? '0 : r_idx + 1'b1;
      end
      if (w_overrun) begin
        r_err_overrun <= 1'b1;
      end
    end
  end

  assign shiftUsed  = r_shift_used;
  assign errShift   = r_err_shift;
  assign errOverrun = r_err_overrun;

endmodule

// File: tb/tb_rs_omega_shift_ctrl.sv
// ----------------------------------------------------------------------------
// tb_rs_omega_shift_ctrl
//
// Directed and randomized bench for rs_omega_shift_ctrl. Expected symbols,
// shift, error flags and first-valid latency come from a behavioural model
// written directly from the shift rule. Inputs are driven and outputs are
// sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_rs_omega_shift_ctrl;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        enable;
  logic        startPls;
  logic [4:0]  numShiftedIn;
  logic [63:0] omegaIn;
  logic        outReady;
  logic        outValid;
  logic [7:0]  outData;
  logic [2:0]  outIndex;
  logic        outLast;
  logic        busy;
  logic [4:0]  shiftUsed;
  logic        errShift;
  logic        errOverrun;

  int checks = 0;
  int errors = 0;
  bit exp_ovr = 1'b0;

  rs_omega_shift_ctrl dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .enable       (enable),
    .startPls     (startPls),
    .numShiftedIn (numShiftedIn),
    .omegaIn      (omegaIn),
    .outReady     (outReady),
    .outValid     (outValid),
    .outData      (outData),
    .outIndex     (outIndex),
    .outLast      (outLast),
    .busy         (busy),
    .shiftUsed    (shiftUsed),
    .errShift     (errShift),
    .errOverrun   (errOverrun)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Shifted symbol i: omega_(i+s) when 8 <= s and i+s <= 15, else zero.
  function automatic logic [7:0] ref_sym(input logic [63:0] om, input int s, input int i);
    if (s < 8 || i + s > 15) return 8'h00;
    return om[8*(i+s-8) +: 8];
  endfunction

  task automatic check_outputs_zero(input string tag);
    check({tag, ".valid"},  outValid,   0);
    check({tag, ".data"},   outData,    0);
    check({tag, ".index"},  outIndex,   0);
    check({tag, ".last"},   outLast,    0);
    check({tag, ".busy"},   busy,       0);
    check({tag, ".shift"},  shiftUsed,  0);
    check({tag, ".errsh"},  errShift,   0);
    check({tag, ".errovr"}, errOverrun, 0);
  endtask

  // rmode: 0 ready always, 1 ready pattern 1,0,0 repeating, 2 random ready.
  // freeze_beat: beat at which enable is dropped for 3 cycles (-1 for none).
  // ovr: issue extra starts at beat 3 and on the beat-7 transfer.
  task automatic run_block(input logic [63:0] om, input int s_in, input int rmode,
                           input int freeze_beat, input bit ovr, input string name);
    int s;
    int lat;
    int k;
    int cyc;
    bit err;
    bit frozen;
    bit r;
`ifdef RS_OMEGA_AUTO_SHIFT_EN
    s = 16;
    for (int j = 15; j >= 8; j--) begin
      if (om[8*(j-8) +: 8] != 8'h00) s = j;
    end
    err = 1'b0;
    lat = (s <= 15) ? (2 + s - 8) : 9;
`else
    s   = s_in;
    err = (s_in < 8) || (s_in > 15);
    lat = 1;
`endif
    @(negedge CLK);
    check({name, ".idle_busy"}, busy, 0);
    enable       = 1'b1;
    startPls     = 1'b1;
    omegaIn      = om;
    numShiftedIn = s_in[4:0];
    outReady     = 1'b0;
    @(negedge CLK);
    startPls = 1'b0;
    for (int w = 1; w < lat; w++) begin
      check({name, ".pre_valid"}, outValid, 0);
      check({name, ".pre_busy"},  busy,     1);
      @(negedge CLK);
    end
    check({name, ".shift"}, shiftUsed, s);
    check({name, ".errsh"}, errShift,  err);
    k      = 0;
    cyc    = 0;
    frozen = 1'b0;
    while (k < 8 && cyc < 200) begin
      if (!frozen && k == freeze_beat) begin
        frozen   = 1'b1;
        enable   = 1'b0;
        outReady = 1'b1;
        repeat (3) begin
          check({name, ".frz_valid"}, outValid, 1);
          check({name, ".frz_index"}, outIndex, k);
          check({name, ".frz_data"},  outData,  ref_sym(om, s, k));
          @(negedge CLK);
        end
        enable = 1'b1;
      end
      case (rmode)
        0:       r = 1'b1;
        1:       r = (cyc % 3 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      outReady = r;
      startPls = ovr && r && (k == 3 || k == 7);
      if (startPls) exp_ovr = 1'b1;
      check({name, ".valid"}, outValid, 1);
      check({name, ".index"}, outIndex, k);
      check({name, ".data"},  outData,  ref_sym(om, s, k));
      check({name, ".last"},  outLast,  (k == 7));
      check({name, ".busy"},  busy,     1);
      if (r) k++;
      cyc++;
      @(negedge CLK);
    end
    startPls = 1'b0;
    outReady = 1'b0;
    check({name, ".beats"},     k,          8);
    check({name, ".end_valid"}, outValid,   0);
    check({name, ".end_busy"},  busy,       0);
    check({name, ".end_shift"}, shiftUsed,  s);
    check({name, ".end_errsh"}, errShift,   err);
    check({name, ".end_ovr"},   errOverrun, exp_ovr);
    $display("block %s: shift_in=%0d shift=%0d err=%0d beats=%0d cycles=%0d", name, s_in, s, err, k, cyc);
  endtask

  // Start a block, then assert RESET asynchronously while index 4 is presented.
  task automatic reset_mid(input logic [63:0] om);
    int n;
    @(negedge CLK);
    enable       = 1'b1;
    startPls     = 1'b1;
    omegaIn      = om;
    numShiftedIn = 5'd8;
    outReady     = 1'b1;
    @(negedge CLK);
    startPls = 1'b0;
    n = 0;
    while (!(outValid && outIndex == 3'd4) && n < 40) begin
      @(negedge CLK);
      n++;
    end
    check("rst.reach_idx4", outIndex, 4);
    #2 RESET = 1'b1;
    #1 check_outputs_zero("rst.abort");
    @(negedge CLK);
    RESET    = 1'b0;
    outReady = 1'b0;
    exp_ovr  = 1'b0;
    @(negedge CLK);
    check_outputs_zero("rst.after");
    $display("reset mid-block after %0d cycles", n);
  endtask

  initial begin
    logic [63:0] om_a;
    logic [63:0] om_r;
    int          s_r;

    om_a         = 64'h0807060504030201;
    RESET        = 1'b1;
    enable       = 1'b0;
    startPls     = 1'b0;
    outReady     = 1'b0;
    numShiftedIn = 5'd0;
    omegaIn      = 64'd0;
    #12 check_outputs_zero("reset_hold");
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    check_outputs_zero("reset_release");

    run_block(om_a, 8,  0, -1, 1'b0, "t1_s8");
    run_block(om_a, 13, 0, -1, 1'b0, "t2_s13");
    run_block(om_a, 5,  0, -1, 1'b0, "t3_s5");
    run_block(om_a, 8,  0, -1, 1'b0, "t3_clear");
    run_block(om_a, 10, 1,  4, 1'b0, "t4_stall_freeze");
    run_block(om_a, 8,  0, -1, 1'b1, "t5_overrun");
    run_block(om_a, 9,  2, -1, 1'b0, "t5_sticky");
    reset_mid(om_a);
    run_block(om_a, 8,  0, -1, 1'b0, "t5_fresh");
    run_block(64'h55443322AA000000, 8, 0, -1, 1'b0, "t6_scan");
    run_block(64'h0, 12, 0, -1, 1'b0, "t6_zero");
    run_block(om_a, 15, 1, -1, 1'b0, "t_s15");
    run_block(om_a, 16, 0, -1, 1'b0, "t_s16");

    for (int b = 0; b < 20; b++) begin
      om_r = 64'd0;
      for (int y = 0; y < 8; y++) begin
        if ($urandom_range(0, 1) == 1) om_r[8*y +: 8] = 8'($urandom_range(1, 255));
      end
      s_r = $urandom_range(0, 31);
      run_block(om_r, s_r, 2, (b % 4 == 0) ? 2 : -1, 1'b0, $sformatf("rnd%0d", b));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
